// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_queue.sv
// Circular buffer of pending register writes: up to two pushes and one pop per cycle.
// With WRITEBACK_FORWARD_EN defined, the read pointer and all slots are exported for forwarding.
module wb_entry_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push0_valid,
  input  wb_entry_t                push0_entry,
  input  logic                     push1_valid,
  input  wb_entry_t                push1_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
`ifdef WRITEBACK_FORWARD_EN
  ,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output wb_entry_t                entries [DEPTH]
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_push;
  logic [PTR_W-1:0] slot1;

  // push1 lands after push0 when both are present, otherwise at the write pointer
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    n_push   = {1'b0, push0_valid} + {1'b0, push1_valid};
    slot1    = wr_ptr_q + PTR_W'(push0_valid);
    if (push0_valid) mem_d[wr_ptr_q] = push0_entry;
    if (push1_valid) mem_d[slot1] = push1_entry;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    count_d  = count_q - CNT_W'(pop) + CNT_W'(n_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

`ifdef WRITEBACK_FORWARD_EN
  assign rd_ptr  = rd_ptr_q;
  assign entries = mem_q;
`endif

endmodule

// File: rtl/writeback_queue.sv
// Write-back stage: accepts ALU and load results, queues them in order and drives the register-file write port.
// Define WRITEBACK_FORWARD_EN to add the fwd_* lookup ports and youngest-match search.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data
`ifdef WRITEBACK_FORWARD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] queue_count;
  wb_entry_t        head;
  wb_entry_t        mem_e, alu_e;
  logic             mem_keep, alu_keep;
  logic             pop;
  logic             push0_valid, push1_valid;
  wb_entry_t        push0_entry, push1_entry;
  logic             we_q, we_d;
  wb_entry_t        out_q, out_d;

  // Leaves room for a dual push even when nothing pops
  assign in_ready = (queue_count <= CNT_W'(DEPTH - 2));

  assign mem_e    = '{addr: mem_addr, data: mem_data};
  assign alu_e    = '{addr: alu_addr, data: alu_data};
  assign mem_keep = mem_valid && in_ready && (mem_addr != REG_ZERO);
  assign alu_keep = alu_valid && in_ready && (alu_addr != REG_ZERO);

  // Output source priority: queue head, then oldest surviving input; the rest is pushed oldest first
  always_comb begin
    pop         = 1'b0;
    push0_valid = 1'b0;
    push0_entry = mem_e;
    push1_valid = 1'b0;
    push1_entry = alu_e;
    we_d        = 1'b0;
    out_d       = out_q;
    if (queue_count != '0) begin
      pop   = 1'b1;
      we_d  = 1'b1;
      out_d = head;
      if (mem_keep) begin
        push0_valid = 1'b1;
        push1_valid = alu_keep;
      end else if (alu_keep) begin
        push0_valid = 1'b1;
        push0_entry = alu_e;
      end
    end else if (mem_keep) begin
      we_d        = 1'b1;
      out_d       = mem_e;
      push0_valid = alu_keep;
      push0_entry = alu_e;
    end else if (alu_keep) begin
      we_d  = 1'b1;
      out_d = alu_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = out_q.addr;
  assign write_data   = out_q.data;

`ifdef WRITEBACK_FORWARD_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] q_rd_ptr;
  wb_entry_t        q_entries [DEPTH];

  wb_entry_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0_valid (push0_valid),
    .push0_entry (push0_entry),
    .push1_valid (push1_valid),
    .push1_entry (push1_entry),
    .pop         (pop),
    .head        (head),
    .count       (queue_count),
    .rd_ptr      (q_rd_ptr),
    .entries     (q_entries)
  );

  // Scan oldest to youngest so the last match wins; the output register is older than any queued entry
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (we_q && (out_q.addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = out_q.data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = q_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < queue_count) && (q_entries[idx].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_entries[idx].data;
      end
    end
    if (fwd_addr == REG_ZERO) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  wb_entry_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0_valid (push0_valid),
    .push0_entry (push0_entry),
    .push1_valid (push1_valid),
    .push1_entry (push1_entry),
    .pop         (pop),
    .head        (head),
    .count       (queue_count)
  );
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH = 4).
module tb_writeback_queue;
  import wb_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0]     alu_data;
  logic                  in_ready;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;
`ifdef WRITEBACK_FORWARD_EN
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic                  fwd_hit;
  logic [DATA_W-1:0]     fwd_data;
`endif

  int unsigned total;
  int unsigned passed;

  writeback_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
`ifdef WRITEBACK_FORWARD_EN
    ,
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic set_pair(input int p);
    drive(1'b1, 5'(8 + 2 * p), 32'h1000 + 32'(8 + 2 * p),
          1'b1, 5'(9 + 2 * p), 32'h1000 + 32'(9 + 2 * p));
  endtask

  initial begin
    int  pair;
    int  k;
    bit  rdy;
    bit  saw_stall;
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    idle();
`ifdef WRITEBACK_FORWARD_EN
    fwd_addr = 5'd0;
`endif

    // reset state
    #2;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(dut.queue_count), 32'd0);
`ifdef WRITEBACK_FORWARD_EN
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
`endif
    #10 rst_n = 1'b1;

    // single ALU write bypasses the empty queue
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_00AA);
    step();
    chk("single_we", 32'(write_enable), 32'd1);
    chk("single_addr", 32'(write_addr), 32'd5);
    chk("single_data", write_data, 32'hAA);
    idle();
    step();
    chk("single_we_off", 32'(write_enable), 32'd0);
    chk("single_addr_hold", 32'(write_addr), 32'd5);
    chk("single_data_hold", write_data, 32'hAA);

    // dual push into empty queue: mem first, alu next cycle
    drive(1'b1, 5'd2, 32'h11, 1'b1, 5'd3, 32'h22);
    step();
    idle();
    chk("dual_addr0", 32'(write_addr), 32'd2);
    chk("dual_data0", write_data, 32'h11);
    chk("dual_count", 32'(dut.queue_count), 32'd1);
    step();
    chk("dual_we1", 32'(write_enable), 32'd1);
    chk("dual_addr1", 32'(write_addr), 32'd3);
    chk("dual_data1", write_data, 32'h22);
    chk("dual_count_end", 32'(dut.queue_count), 32'd0);
    step();
    chk("dual_we_off", 32'(write_enable), 32'd0);

    // four dual pushes held through back-pressure; writes 8..15 in order
    pair = 0;
    k = 0;
    saw_stall = 1'b0;
    set_pair(0);
    for (int c = 0; c < 40 && k < 8; c++) begin
      rdy = in_ready;
      if (!rdy) saw_stall = 1'b1;
      step();
      if (write_enable) begin
        chk("burst_addr", 32'(write_addr), 32'(8 + k));
        chk("burst_data", write_data, 32'h1000 + 32'(8 + k));
        k++;
      end
      if (pair < 4 && rdy) begin
        pair++;
        if (pair < 4) set_pair(pair);
        else idle();
      end
    end
    chk("burst_writes", 32'(k), 32'd8);
    chk("burst_stalled", 32'(saw_stall), 32'd1);
    step();
    chk("burst_we_off", 32'(write_enable), 32'd0);

    // register 31 is dropped at acceptance
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd31, 32'hFF);
    step();
    idle();
    chk("zero_addr", 32'(write_addr), 32'd7);
    chk("zero_data", write_data, 32'h77);
    chk("zero_count", 32'(dut.queue_count), 32'd0);
    step();
    chk("zero_we_off", 32'(write_enable), 32'd0);

`ifdef WRITEBACK_FORWARD_EN
    // youngest pending write to r4 wins over the older one in the output register
    drive(1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
    step();
    idle();
    fwd_addr = 5'd4;
    #1;
    chk("fwd_hit4", 32'(fwd_hit), 32'd1);
    chk("fwd_data4", fwd_data, 32'h2);
    fwd_addr = 5'd31;
    #1;
    chk("fwd_hit31", 32'(fwd_hit), 32'd0);
    fwd_addr = 5'd6;
    #1;
    chk("fwd_hit6", 32'(fwd_hit), 32'd0);
    step();
    step();
    chk("fwd_drain_we", 32'(write_enable), 32'd0);
`endif

    // fill to three pending entries, then reset mid-cycle
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
    step();
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    step();
    drive(1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25);
    step();
    idle();
    chk("prefill_count", 32'(dut.queue_count), 32'd3);
    chk("prefill_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(write_enable), 32'd0);
    chk("midrst_count", 32'(dut.queue_count), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("postrst_we", 32'(write_enable), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
